// File: rtl/wrapper_result_fifo.sv
// Result FIFO on the consumer side of the exponential wrapper write port.
// Optional sticky overflow flag built when RESULT_FIFO_OVF_EN is defined.
module wrapper_result_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 21,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_reg,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf
);

    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt_q;
    logic          push_c;
    logic          pop_c;

    // Flags come from the occupancy register only, never from pointer compare.
    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign rd_valid = !empty;
    assign pop_c    = rd_valid && rd_ready;
    assign push_c   = wr_reg && (!full || pop_c);
    assign rd_data  = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt_q <= '0;
        end else begin
            if (push_c) wp <= wp + AW'(1);
            if (pop_c)  rp <= rp + AW'(1);
            case ({push_c, pop_c})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is not reset; a push in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (!rst && push_c) mem[wp] <= wr_data;
    end

`ifdef RESULT_FIFO_OVF_EN
    logic ovf_q;

    // Sticky: any write while full with no pop is a dropped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (wr_reg && full && !pop_c) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_wrapper_result_fifo.sv
// Scoreboard bench for wrapper_result_fifo: stimulus queues expected words,
// a negedge monitor pops and compares on every read handshake.
module tb_wrapper_result_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 21;
    localparam int unsigned AW    = 3;
`ifdef RESULT_FIFO_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_reg = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    wrapper_result_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .full(full), .empty(empty), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the expected word is queued when the write will be accepted.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        wr_reg   = w;
        wr_data  = d;
        rd_ready = r;
        if (w && (exp_q.size() < DEPTH || (r && exp_q.size() > 0))) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic w, input logic r);
        rst      = 1'b1;
        wr_reg   = w;
        wr_data  = 21'h1234;
        rd_ready = r;
        exp_q.delete();
        repeat (n) @(posedge clk);
        #1;
        rst    = 1'b0;
        wr_reg = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        chk({name, " drain done"}, 32'(exp_q.size()), 32'd0);
        cycle(1'b0, '0, 1'b0);
        chk({name, " empty after drain"}, 32'(empty), 32'd1);
    endtask

    // Monitor: a handshake seen mid-cycle means the head word leaves at the next edge.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: unexpected word %0h with empty scoreboard", rd_data);
            end else begin
                if (rd_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL monitor rd_data: got %0h expected %0h", rd_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // Reset then idle
        do_reset(2, 1'b0, 1'b0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);

        // Single word, 1-cycle latency; ready while empty does nothing
        cycle(1'b0, 21'h1F0F0F, 1'b1);
        chk("idle ready count", 32'(count), 32'd0);
        cycle(1'b1, 21'h0ABCDE, 1'b0);
        chk("single rd_valid", 32'(rd_valid), 32'd1);
        chk("single rd_data", 32'(rd_data), 32'h0ABCDE);
        chk("single count", 32'(count), 32'd1);
        cycle(1'b0, '0, 1'b1);
        chk("single empty", 32'(empty), 32'd1);
        chk("single rd_data gated", 32'(rd_data), 32'd0);

        // Fill 1..8 then overflow write
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0);
        chk("fill full", 32'(full), 32'd1);
        chk("fill count", 32'(count), 32'd8);
        chk("fill head", 32'(rd_data), 32'd1);
        cycle(1'b1, 21'h1FFFFF, 1'b0);
        chk("ovf count", 32'(count), 32'd8);
        chk("ovf flag", 32'(ovf), 32'(OVF_EN));
        cycle(1'b0, '0, 1'b0);
        chk("ovf sticky", 32'(ovf), 32'(OVF_EN));
        drain("ovf", 12);
        chk("ovf after drain", 32'(ovf), 32'(OVF_EN));

        // Full with simultaneous push and pop
        do_reset(1, 1'b0, 1'b0);
        chk("reset clears ovf", 32'(ovf), 32'd0);
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0);
        cycle(1'b1, 21'd9, 1'b1);
        chk("pushpop count", 32'(count), 32'd8);
        chk("pushpop full", 32'(full), 32'd1);
        chk("pushpop ovf", 32'(ovf), 32'd0);
        chk("pushpop head", 32'(rd_data), 32'd2);
        drain("pushpop", 12);

        // Wrap: 20 words, rd_ready toggling; source holds off while full and not reading
        s = 0;
        for (int c = 0; c < 60 && s < 20; c++) begin
            if (exp_q.size() >= DEPTH && c % 2 == 0) begin
                cycle(1'b0, '0, 1'(c % 2));
            end else begin
                cycle(1'b1, DW'(32'h100 + s), 1'(c % 2));
                s++;
            end
        end
        chk("wrap words issued", 32'(s), 32'd20);
        drain("wrap", 24);

        // Reset mid-traffic with three words stored
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'h50 + i), 1'b0);
        chk("pre-reset count", 32'(count), 32'd3);
        do_reset(1, 1'b1, 1'b1);
        chk("midreset empty", 32'(empty), 32'd1);
        chk("midreset count", 32'(count), 32'd0);
        chk("midreset rd_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b1, DW'(32'hA0 + i), 1'b0);
        chk("post-reset full", 32'(full), 32'd1);
        chk("post-reset head", 32'(rd_data), 32'hA0);
        drain("post-reset", 12);

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
